// File: rtl/mc_core_ctrl_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package mc_core_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/mc_core_ctrl_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memories.
interface mc_core_ctrl_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ready_i;
  logic [31:0]     imem_rdata_i;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic            dmem_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o,
    input  imem_ready_i, imem_rdata_i, dmem_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o,
    output imem_ready_i, imem_rdata_i, dmem_ready_i
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive wait cycles of the active memory handshake and flags a bus timeout.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  // The limit-th cycle without ready times out; a ready on that same cycle wins.
  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 w_waiting;

  assign w_waiting = i_active && !i_ready;
  assign o_timeout = w_waiting && (r_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_waiting && !o_timeout) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle sequencer: owns PC, instruction register, stage strobes, trap and counters.
module mc_core_ctrl
  import mc_core_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     TIMEOUT_W = 4,
  parameter int unsigned     CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  mc_core_ctrl_if.master   mem_bus,
  input  logic             is_load_i,
  input  logic             is_store_i,
  input  logic             branch_jump_i,
  input  logic [XLEN-1:0]  target_pc_i,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             rd_we_o,
  output logic             retire_o,
  output logic             trap_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
);

  state_e            r_state;
  state_e            w_state_next;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_tgt;
  logic              r_taken;
  logic [31:0]       r_inst;
  logic              r_trap;
  logic [CNT_W-1:0]  r_cycle;
  logic [CNT_W-1:0]  r_instret;
  logic              w_imem_req;
  logic              w_dmem_req;
  logic              w_dmem_we;
  logic              w_rd_we;
  logic              w_retire;
  logic              w_wait_active;
  logic              w_wait_ready;
  logic              w_timeout;

  // FETCH and MEM are exclusive, so one timer serves both handshakes.
  assign w_wait_active = (r_state == StFetch) || (r_state == StMem);
  assign w_wait_ready  = (r_state == StFetch) ? mem_bus.imem_ready_i : mem_bus.dmem_ready_i;

  mem_wait_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_mem_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_wait_active),
    .i_ready   (w_wait_ready),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_state_next = r_state;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_rd_we      = 1'b0;
    w_retire     = 1'b0;
    unique case (r_state)
      StFetch: begin
        w_imem_req = 1'b1;
        if (mem_bus.imem_ready_i) w_state_next = StDecode;
        else if (w_timeout)       w_state_next = StHalt;
      end
      StDecode: w_state_next = StExec;
      StExec:   w_state_next = (is_load_i || is_store_i) ? StMem : StWb;
      StMem: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = is_store_i;
        if (mem_bus.dmem_ready_i) w_state_next = StWb;
        else if (w_timeout)       w_state_next = StHalt;
      end
      StWb: begin
        w_rd_we      = !(is_store_i || r_taken);
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StFetch;
      r_pc      <= RESET_PC;
      r_tgt     <= '0;
      r_taken   <= 1'b0;
      r_inst    <= NOP_INST;
      r_trap    <= 1'b0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      r_cycle <= r_cycle + CNT_W'(1);
      if (w_timeout) r_trap <= 1'b1;
      if (r_state == StFetch && mem_bus.imem_ready_i) r_inst <= mem_bus.imem_rdata_i;
      if (r_state == StExec) begin
        r_taken <= branch_jump_i;
        r_tgt   <= target_pc_i;
      end
      if (r_state == StWb) begin
        r_pc      <= r_taken ? r_tgt : r_pc + XLEN'(4);
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign mem_bus.imem_req_o  = w_imem_req;
  assign mem_bus.imem_addr_o = r_pc;
  assign mem_bus.dmem_req_o  = w_dmem_req;
  assign mem_bus.dmem_we_o   = w_dmem_we;
  assign inst_o              = r_inst;
  assign pc_o                = r_pc;
  assign rd_we_o             = w_rd_we;
  assign retire_o            = w_retire;
  assign trap_o              = r_trap;
  assign cycle_cnt_o         = r_cycle;
  assign instret_cnt_o       = r_instret;

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Self-checking bench for mc_core_ctrl: vector table, corner sequences and a random stream.
module tb_mc_core_ctrl;
  import mc_core_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [31:0] I_ADDI = 32'h0010_0093;
  localparam logic [31:0] I_LW   = 32'h0000_a103;
  localparam logic [31:0] I_SW   = 32'h0020_a023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006f;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_load, is_store, branch_jump;
  logic [31:0] target_pc, inst, pc;
  logic        rd_we, retire, trap;
  logic [63:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  mc_core_ctrl_if #(.XLEN(XLEN)) bus ();

  mc_core_ctrl #(
    .XLEN      (XLEN),
    .RESET_PC  (RST_PC),
    .TIMEOUT_W (4),
    .CNT_W     (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_bus       (bus),
    .is_load_i     (is_load),
    .is_store_i    (is_store),
    .branch_jump_i (branch_jump),
    .target_pc_i   (target_pc),
    .inst_o        (inst),
    .pc_o          (pc),
    .rd_we_o       (rd_we),
    .retire_o      (retire),
    .trap_o        (trap),
    .cycle_cnt_o   (cycle_cnt),
    .instret_cnt_o (instret_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    int          f;        // cycle (1-based) of fetch ready
    int          m;        // cycle (1-based) of data ready
    bit          ld;
    bit          st;
    bit          tk;
    logic [31:0] tgt;
    int          exp_cyc;  // cycles from FETCH entry to retire, inclusive
    logic [31:0] exp_pc;   // PC after retire
  } vec_t;

  vec_t vecs[11];

  int n_pass = 0;
  int n_total = 0;

  // Architectural model state.
  logic [31:0] m_pc, m_inst;
  logic [63:0] m_cyc, m_instret;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [5:0] strobes();
    return {bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, rd_we, retire, trap};
  endfunction

  task automatic check_arch(input string tag, input logic [5:0] exp_strb);
    chk({tag, " strobes"}, 128'(strobes()), 128'(exp_strb));
    chk({tag, " pc/addr"}, 128'({pc, bus.imem_addr_o}), 128'({m_pc, m_pc}));
    chk({tag, " inst"}, 128'(inst), 128'(m_inst));
    chk({tag, " counters"}, {cycle_cnt, instret_cnt}, {m_cyc, m_instret});
  endtask

  task automatic drive_idle();
    bus.imem_ready_i = 1'b0;
    bus.imem_rdata_i = $urandom;
    bus.dmem_ready_i = 1'b0;
    is_load          = 1'b0;
    is_store         = 1'b0;
    branch_jump      = 1'b0;
    target_pc        = '0;
  endtask

  // Enter at a negedge, leave at a negedge with rst just released.
  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    m_pc = RST_PC; m_inst = NOP; m_cyc = '0; m_instret = '0;
    #1;
    check_arch("reset", 6'b100000);
    rst = 1'b0;
  endtask

  // One instruction following the nominal schedule FETCH(f) DECODE EXEC [MEM(m)] WB.
  task automatic run_inst(input vec_t v, input bit noise, output int ret_k);
    int total;
    bit ls;
    ls    = v.ld || v.st;
    total = v.f + 2 + (ls ? v.m : 0) + 1;
    ret_k = -1;
    for (int k = 0; k < total; k++) begin
      bit ph_fetch, ph_exec, ph_mem, ph_wb;
      ph_fetch = (k < v.f);
      ph_exec  = (k == v.f + 1);
      ph_mem   = ls && (k >= v.f + 2) && (k < v.f + 2 + v.m);
      ph_wb    = (k == total - 1);
      bus.imem_ready_i = ph_fetch ? (k == v.f - 1) : (noise && ($urandom_range(0, 1) == 1));
      bus.imem_rdata_i = (ph_fetch && k == v.f - 1) ? v.inst : $urandom;
      bus.dmem_ready_i = ph_mem ? (k == v.f + 1 + v.m) : (noise && ($urandom_range(0, 1) == 1));
      is_load          = v.ld;
      is_store         = v.st;
      branch_jump      = ph_exec ? v.tk : ($urandom_range(0, 1) == 1);
      target_pc        = ph_exec ? v.tgt : $urandom;
      #1;
      check_arch($sformatf("k%0d", k),
                 {ph_fetch, ph_mem, ph_mem && v.st, ph_wb && !v.st && !v.tk, ph_wb, 1'b0});
      if (retire && ret_k < 0) ret_k = k;
      @(posedge clk);
      m_cyc++;
      if (ph_fetch && k == v.f - 1) m_inst = v.inst;
      if (ph_wb) begin
        m_pc = v.tk ? v.tgt : m_pc + 32'd4;
        m_instret++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int   rk;
    vec_t rv;

    vecs[0]  = '{I_ADDI, 1,  0, 0, 0, 0, 32'h0,         4,  32'h8000_0004};
    vecs[1]  = '{I_ADDI, 1,  0, 0, 0, 0, 32'h0,         4,  32'h8000_0008};
    vecs[2]  = '{I_ADDI, 1,  0, 0, 0, 0, 32'h0,         4,  32'h8000_000C};
    vecs[3]  = '{I_LW,   1,  4, 1, 0, 0, 32'h0,         8,  32'h8000_0010};
    vecs[4]  = '{I_SW,   2,  1, 0, 1, 0, 32'h0,         6,  32'h8000_0014};
    vecs[5]  = '{I_BEQ,  1,  0, 0, 0, 1, 32'h8000_0100, 4,  32'h8000_0100};
    vecs[6]  = '{I_BEQ,  1,  0, 0, 0, 0, 32'h8000_0200, 4,  32'h8000_0104};
    vecs[7]  = '{I_ADDI, 15, 0, 0, 0, 0, 32'h0,         18, 32'h8000_0108};
    vecs[8]  = '{I_LW,   1,  15, 1, 0, 0, 32'h0,        19, 32'h8000_010C};
    vecs[9]  = '{I_JAL,  1,  0, 0, 0, 1, 32'hFFFF_FFFC, 4,  32'hFFFF_FFFC};
    vecs[10] = '{I_ADDI, 1,  0, 0, 0, 0, 32'h0,         4,  32'h0000_0000};

    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      run_inst(vecs[i], i >= 3, rk);
      chk($sformatf("vec%0d retire cycle", i), 128'(rk + 1), 128'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d next pc", i), 128'(pc), 128'(vecs[i].exp_pc));
      if (i == 2) chk("addi stream counters", {cycle_cnt, instret_cnt}, {64'd12, 64'd3});
    end

    // Fetch never answered: trap after 15 wait cycles, then frozen except cycle count.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive_idle();
      #1;
      check_arch($sformatf("to%0d", k), 6'b100000);
      @(posedge clk); m_cyc++; @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      drive_idle();
      bus.imem_ready_i = 1'b1;
      bus.dmem_ready_i = 1'b1;
      #1;
      check_arch($sformatf("halt%0d", k), 6'b000001);
      @(posedge clk); m_cyc++; @(negedge clk);
    end
    chk("halt cycle count", 128'(cycle_cnt), 128'(64'd20));

    // Reset during a data wait, followed by a stale data ready.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_idle();
      bus.imem_ready_i = (k == 0);
      bus.imem_rdata_i = I_LW;
      is_load          = 1'b1;
      #1;
      chk($sformatf("mem wait req k%0d", k), 128'(bus.dmem_req_o), 128'(k >= 3));
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_pc = RST_PC; m_inst = NOP; m_cyc = '0; m_instret = '0;
    for (int k = 0; k < 3; k++) begin
      drive_idle();
      bus.dmem_ready_i = 1'b1;
      is_load          = 1'b1;
      #1;
      check_arch($sformatf("stale%0d", k), 6'b100000);
      @(posedge clk); m_cyc++; @(negedge clk);
    end

    // Random instruction stream with ready noise outside the waiting states.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int typ;
      typ     = $urandom_range(0, 2);
      rv.inst = $urandom;
      rv.f    = $urandom_range(1, 15);
      rv.m    = $urandom_range(1, 15);
      rv.ld   = (typ == 1);
      rv.st   = (typ == 2);
      rv.tk   = ($urandom_range(0, 1) == 1);
      rv.tgt  = $urandom & 32'hFFFF_FFFC;
      rv.exp_cyc = 0;
      rv.exp_pc  = '0;
      run_inst(rv, 1'b1, rk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
